key_entry_ctrl: RTL and testbench



---
 rtl/key_entry_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: debounces decoded key events, edits a 4-digit hex
// buffer, and time-multiplexes that buffer onto a 4-digit 7-segment display.
module key_entry_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd26999,
    parameter logic [2:0]  DEB_CNT  = 3'd3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        key_tick,
    input  logic        key_pushed,
    input  logic [3:0]  key_value,
    output logic [3:0]  dig,
    output logic [3:0]  hex,
    output logic [15:0] entry,
    output logic [2:0]  count,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [2:0]  deb_q, deb_d;
    logic        fire;

    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] result_q, result_d;
    logic        rv_q, rv_d;
    logic        ov_q, ov_d;

    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  dig_q, dig_d;
    logic [3:0]  hex_q, hex_d;

    // Debounce/hold FSM; fire marks the single accepting tick of a press.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        deb_d   = deb_q;
        fire    = 1'b0;
        if (key_tick) begin
            case (state_q)
                IDLE: begin
                    if (key_pushed) begin
                        key_d = key_value;
                        deb_d = 3'd1;
                        if (DEB_CNT <= 3'd1) begin
                            fire    = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (!key_pushed) begin
                        state_d = IDLE;
                    end else if (key_value != key_q) begin
                        key_d = key_value;
                        deb_d = 3'd1;
                    end else begin
                        deb_d = deb_q + 3'd1;
                        if (deb_d >= DEB_CNT) begin
                            fire    = 1'b1;
                            state_d = HELD;
                        end
                    end
                end
                HELD: begin
                    if (!key_pushed) begin
                        deb_d   = 3'd1;
                        state_d = (DEB_CNT <= 3'd1) ? IDLE : REL;
                    end
                end
                REL: begin
                    if (key_pushed) begin
                        state_d = HELD;
                    end else begin
                        deb_d = deb_q + 3'd1;
                        if (deb_d >= DEB_CNT) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Edit commands; key_d holds the accepted key on the firing cycle.
    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        result_d = result_q;
        rv_d     = 1'b0;
        ov_d     = 1'b0;
        if (fire) begin
            if (key_d <= 4'h9) begin
                if (count_q < 3'd4) begin
                    entry_d = {entry_q[11:0], key_d};
                    count_d = count_q + 3'd1;
                end else begin
                    ov_d = 1'b1;
                end
            end else begin
                case (key_d)
                    4'hC: begin
                        entry_d = 16'h0;
                        count_d = 3'd0;
                    end
                    4'hE: begin
                        if (count_q != 3'd0) begin
                            entry_d = {4'h0, entry_q[15:4]};
                            count_d = count_q - 3'd1;
                        end
                    end
                    4'hF: begin
                        if (count_q != 3'd0) begin
                            result_d = entry_q;
                            rv_d     = 1'b1;
                            entry_d  = 16'h0;
                            count_d  = 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Display scan: digit0 is never blanked so an empty buffer reads "0".
    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        idx_d      = idx_q;
        dig_d      = dig_q;
        hex_d      = hex_q;
        if (scan_cnt_q == SCAN_DIV) begin
            scan_cnt_d = 16'd0;
            idx_d      = idx_q + 2'd1;
            hex_d      = entry_q[{idx_d, 2'b00} +: 4];
            if (({1'b0, idx_d} >= count_q) && (idx_d != 2'd0))
                dig_d = 4'b1111;
            else
                dig_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            key_q      <= 4'h0;
            deb_q      <= 3'd0;
            entry_q    <= 16'h0;
            count_q    <= 3'd0;
            result_q   <= 16'h0;
            rv_q       <= 1'b0;
            ov_q       <= 1'b0;
            scan_cnt_q <= 16'd0;
            idx_q      <= 2'd0;
            dig_q      <= 4'b1110;
            hex_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            deb_q      <= deb_d;
            entry_q    <= entry_d;
            count_q    <= count_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            ov_q       <= ov_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_q      <= dig_d;
            hex_q      <= hex_d;
        end
    end

    assign dig          = dig_q;
    assign hex          = hex_q;
    assign entry        = entry_q;
    assign count        = count_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign overflow     = ov_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: table of key presses plus hand-written
// reset, debounce, release-bounce and display-scan sequences.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        key_tick = 1'b0;
    logic        key_pushed = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic [3:0]  dig, hex;
    logic [15:0] entry, result;
    logic [2:0]  count;
    logic        result_valid, overflow;

    key_entry_ctrl #(.SCAN_DIV(16'd3), .DEB_CNT(3'd3)) dut (
        .clk(clk), .nrst(nrst), .key_tick(key_tick), .key_pushed(key_pushed),
        .key_value(key_value), .dig(dig), .hex(hex), .entry(entry),
        .count(count), .result(result), .result_valid(result_valid),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int ov_cnt  = 0;
    int rv_cnt  = 0;
    int both_cnt = 0;

    // Pulses are one clk wide, so the number of high samples counts pulses.
    always @(negedge clk) begin
        if (nrst) begin
            if (overflow) ov_cnt++;
            if (result_valid) rv_cnt++;
            if (overflow && result_valid) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input logic p, input logic [3:0] v);
        @(negedge clk);
        key_pushed = p;
        key_value  = v;
        key_tick   = 1'b1;
        @(negedge clk);
        key_tick   = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        repeat (3) tick(1'b1, v);
        repeat (3) tick(1'b0, 4'h0);
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] res;
        int          ov;
        int          rv;
    } vec_t;

    vec_t vec[14];

    task automatic scan_check(input string name, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic [3:0] h0, input logic [3:0] h1);
        logic [3:0] prev;
        logic [3:0] ed [4];
        logic [3:0] eh [4];
        bit found;
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        eh[0] = h0; eh[1] = h1; eh[2] = 4'h0; eh[3] = 4'h0;
        found = 1'b0;
        @(negedge clk);
        prev = dig;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev != 4'b1110 && dig == 4'b1110) found = 1'b1;
            else prev = dig;
        end
        check({name, "_sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                if (i != 0) @(negedge clk);
                check($sformatf("%s_dig%0d", name, i), 32'(dig), 32'(ed[i/4]));
                check($sformatf("%s_hex%0d", name, i), 32'(hex), 32'(eh[i/4]));
            end
        end
    endtask

    initial begin
        vec[0]  = '{4'h1, 16'h0001, 3'd1, 16'h0000, 0, 0};
        vec[1]  = '{4'h2, 16'h0012, 3'd2, 16'h0000, 0, 0};
        vec[2]  = '{4'h3, 16'h0123, 3'd3, 16'h0000, 0, 0};
        vec[3]  = '{4'h4, 16'h1234, 3'd4, 16'h0000, 0, 0};
        vec[4]  = '{4'h5, 16'h1234, 3'd4, 16'h0000, 1, 0};
        vec[5]  = '{4'hE, 16'h0123, 3'd3, 16'h0000, 1, 0};
        vec[6]  = '{4'hC, 16'h0000, 3'd0, 16'h0000, 1, 0};
        vec[7]  = '{4'h9, 16'h0009, 3'd1, 16'h0000, 1, 0};
        vec[8]  = '{4'h8, 16'h0098, 3'd2, 16'h0000, 1, 0};
        vec[9]  = '{4'hF, 16'h0000, 3'd0, 16'h0098, 1, 1};
        vec[10] = '{4'hF, 16'h0000, 3'd0, 16'h0098, 1, 1};
        vec[11] = '{4'hA, 16'h0000, 3'd0, 16'h0098, 1, 1};
        vec[12] = '{4'h9, 16'h0009, 3'd1, 16'h0098, 1, 1};
        vec[13] = '{4'h8, 16'h0098, 3'd2, 16'h0098, 1, 1};

        // Reset in the middle of a press.
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) tick(1'b1, 4'h5);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("rst_entry", 32'(entry), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        check("rst_dig", 32'(dig), 32'hE);
        check("rst_hex", 32'(hex), 32'h0);
        nrst = 1'b1;
        tick(1'b1, 4'h5);
        check("rst_abort_entry", 32'(entry), 32'h0);
        repeat (3) tick(1'b0, 4'h0);

        // Debounce: two ticks is too short, three accepts, holding never repeats.
        repeat (2) tick(1'b1, 4'h5);
        repeat (3) tick(1'b0, 4'h0);
        check("deb_short_entry", 32'(entry), 32'h0);
        repeat (2) tick(1'b1, 4'h5);
        check("deb_2tick_entry", 32'(entry), 32'h0);
        tick(1'b1, 4'h5);
        check("deb_3tick_entry", 32'(entry), 32'h0005);
        check("deb_3tick_count", 32'(count), 32'd1);
        repeat (20) tick(1'b1, 4'h5);
        check("deb_hold_entry", 32'(entry), 32'h0005);
        check("deb_hold_count", 32'(count), 32'd1);
        repeat (3) tick(1'b0, 4'h0);

        // Release bounce after accepting 7 must not re-fire.
        repeat (3) tick(1'b1, 4'h7);
        tick(1'b0, 4'h0);
        tick(1'b1, 4'h7);
        repeat (3) tick(1'b0, 4'h0);
        check("bounce_entry", 32'(entry), 32'h0057);
        check("bounce_count", 32'(count), 32'd2);
        // Back in IDLE, so a fresh three-tick press is accepted.
        press(4'h7);
        check("bounce_idle_entry", 32'(entry), 32'h0577);
        check("bounce_idle_count", 32'(count), 32'd3);
        press(4'hC);
        check("clear_entry", 32'(entry), 32'h0);
        check("clear_count", 32'(count), 32'd0);

        // Table-driven edit sequence with cumulative pulse counts.
        for (int i = 0; i < 14; i++) begin
            press(vec[i].key);
            check($sformatf("vec%0d_entry", i), 32'(entry), 32'(vec[i].entry));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vec[i].cnt));
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vec[i].res));
            check($sformatf("vec%0d_ov", i), 32'(ov_cnt), 32'(vec[i].ov));
            check($sformatf("vec%0d_rv", i), 32'(rv_cnt), 32'(vec[i].rv));
        end

        // Display scan with 0x0098 / count 2, then with an empty buffer.
        scan_check("scan98", 4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'h8, 4'h9);
        press(4'hC);
        scan_check("scan0", 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'h0, 4'h0);

        check("pulse_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
